fwd_scoreboard_unit: RTL and testbench
======================================

// Module: fwd_scoreboard_unit
// PURPOSE
//  Parametrised forwarding/hazard unit for the pipelined ARM core. It keeps its own shadow scoreboard of in-flight
//  register writes leaving EX, covering FWD_DEPTH downstream stages (1 = MEM, ... FWD_DEPTH = WB).
//  For NUM_SRC EX-stage operands it produces per-operand bypass selects and a load-use stall.
//  Freeze-aware, so it holds state while the SRAM controller stalls the pipeline.
// PARAMETERS
//  REG_AW     4   register address width
//  NUM_SRC    2   number of EX-stage source operands
//  FWD_DEPTH  2   tracked stages after EX (>=1); stage 1 = nearest (MEM)
//  NO_FWD_REG 15  register index never forwarded (PC)
//  SEL_W      $clog2(FWD_DEPTH+1)  width of each select field (localparam)
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  asynchronous reset, active-high
//  freeze     in   1                  pipeline frozen (SRAM busy); scoreboard holds
//  ex_valid   in   1                  instruction leaving EX this cycle is real (0 = bubble)
//  ex_dest    in   REG_AW             its destination register
//  ex_wb_en   in   1                  it writes the register file
//  ex_mem_r   in   1                  it is a load
//  src_valid  in   NUM_SRC            per-operand "operand is used"
//  src        in   NUM_SRC*REG_AW     packed EX-stage source register numbers, operand i at [i*REG_AW +: REG_AW]
//  sel        out  NUM_SRC*SEL_W      per-operand select: 0 = regfile/ID-EX value, k = stage-k result
//  hazard_stall out 1                 load-use stall request
// BEHAVIOUR
//  - Entry k = {v, dest, load}. On posedge clk with !freeze: entry1 <= {ex_valid&ex_wb_en, ex_dest, ex_mem_r},
//    entry k <= entry k-1. With freeze=1 all entries hold. An entry is visible the cycle after it is sampled.
//  - rst (async) clears every v bit. The reset value of sel is all zeros and of hazard_stall is 0 (both are
//    combinational from the cleared state). Reset mid-operation discards all in-flight records.
//  - sel[i] is combinational. It equals the smallest k with entry k v=1 and dest==src[i], gated by
//    src_valid[i]=1 and src[i]!=NO_FWD_REG; otherwise 0. The youngest writer always wins.
//  - hazard_stall = OR over i of (sel[i]==1 && entry1.load). A load in stage 1 has no data yet.
//    While hazard_stall=1 the core inserts a bubble (ex_valid=0). The next cycle the load is in stage 2, so sel=2 and
//    the stall drops. Stall lasts exactly 1 cycle when freeze=0.
//  - freeze and hazard_stall can be high together: entries hold, and the stall persists until unfrozen.
//  - If several operands hit different stages, each is independent. Duplicate dests in two stages: the youngest wins.
//  - v=0 entries never match, including dest==0 garbage after reset.
// CONFIGURATION
//  FWD_STATS_EN defined: adds outputs fwd_cnt[31:0] and stall_cnt[31:0], reset to 0 by rst.
//    - fwd_cnt += number of operands with sel!=0 and hazard_stall=0, each !freeze cycle.
//    - stall_cnt += 1 on each !freeze cycle with hazard_stall=1.
//    - Both counters saturate at 32'hFFFF_FFFF.
//  FWD_STATS_EN undefined: these ports and this logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package arm_pipe_pkg: typedef sb_entry_t {v, dest, load}, constant PC_REG=15, the select encoding constants
//    SEL_REGFILE=0 and SEL_STAGE_BASE.
//  - One sub-module fwd_match: a single-operand priority comparator over FWD_DEPTH entries. Inputs are src, src_valid
//    and the entries; outputs are sel and a hit-on-load flag. It is instantiated NUM_SRC times via generate.
//  - The top holds the entry shift register, the stall OR-reduction and the optional counters.
// TESTING
//  1 rst=1 then release, src=3,src_valid=1 -> sel=0, hazard_stall=0; ex writes r3 once -> next cycle sel=1, then sel=2, then 0.
//  2 Back-to-back writes r5 (ALU) then r5 again -> operand r5 gets sel=1 (youngest), not 2.
//  3 Load r2 leaves EX; next cycle src0=2 -> hazard_stall=1,sel0=1; bubble inserted -> following cycle sel0=2,hazard_stall=0.
//  4 Write r15 with wb_en -> src=15 stays sel=0. Also src_valid=0 with a match -> sel=0.
//  5 Load r4 in stage1, freeze=1 for 3 cycles -> hazard_stall held 3 cycles, entries unchanged; freeze=0 -> advance.
//  6 FWD_STATS_EN: 2 forwards, then 1 load-use -> fwd_cnt=2, stall_cnt=1; assert rst mid-run -> both 0 and all sel=0 at once.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types for the forwarding scoreboard: entry record, PC index, select encoding.
package arm_pipe_pkg;

  localparam int PC_REG         = 15;
  localparam int SB_DEST_W      = 8;   // widest register address an entry can hold
  localparam int SEL_REGFILE    = 0;
  localparam int SEL_STAGE_BASE = 1;

  typedef struct packed {
    logic                 v;
    logic [SB_DEST_W-1:0] dest;
    logic                 load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Single-operand priority comparator: picks the nearest valid in-flight writer of src.
module fwd_match
  import arm_pipe_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int FWD_DEPTH  = 2,
  parameter int NO_FWD_REG = PC_REG,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_AW-1:0]            src,
  input  logic                         src_valid,
  input  sb_entry_t [FWD_DEPTH-1:0]    entries,
  output logic [SEL_W-1:0]             sel,
  output logic                         hit_load
);

  always_comb begin
    sel      = SEL_W'(SEL_REGFILE);
    hit_load = 1'b0;
    if (src_valid && (src != REG_AW'(NO_FWD_REG))) begin
      // Walk oldest to youngest so the nearest stage overwrites any older hit.
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (entries[k].v && (entries[k].dest == SB_DEST_W'(src))) begin
          sel      = SEL_W'(k + SEL_STAGE_BASE);
          hit_load = (k == 0) && entries[k].load;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit with a freeze-aware shadow scoreboard of in-flight writes.
// Optional FWD_STATS_EN adds saturating forward/stall event counters.
module fwd_scoreboard_unit
  import arm_pipe_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int NO_FWD_REG = PC_REG,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic                        ex_valid,
  input  logic [REG_AW-1:0]           ex_dest,
  input  logic                        ex_wb_en,
  input  logic                        ex_mem_r,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   src,
  output logic [NUM_SRC*SEL_W-1:0]    sel,
  output logic                        hazard_stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                 fwd_cnt,
  output logic [31:0]                 stall_cnt
`endif
);

  sb_entry_t [FWD_DEPTH-1:0] entries;
  logic [NUM_SRC-1:0]        hit_load;

  // entries[0] is stage 1 (MEM); the record ages by one stage per unfrozen cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else if (!freeze) begin
      entries[0].v    <= ex_valid & ex_wb_en;
      entries[0].dest <= SB_DEST_W'(ex_dest);
      entries[0].load <= ex_mem_r;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .REG_AW     (REG_AW),
      .FWD_DEPTH  (FWD_DEPTH),
      .NO_FWD_REG (NO_FWD_REG),
      .SEL_W      (SEL_W)
    ) u_match (
      .src       (src[i*REG_AW +: REG_AW]),
      .src_valid (src_valid[i]),
      .entries   (entries),
      .sel       (sel[i*SEL_W +: SEL_W]),
      .hit_load  (hit_load[i])
    );
  end

  assign hazard_stall = |hit_load;

`ifdef FWD_STATS_EN
  logic [NUM_SRC-1:0] fwd_hit;
  logic [32:0]        fwd_sum;

  always_comb begin
    fwd_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_hit[i] = |sel[i*SEL_W +: SEL_W];
    end
    fwd_sum = {1'b0, fwd_cnt} + 33'($countones(fwd_hit));
  end

  // Stalled cycles count only as stalls; their operand hits are not real forwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      if (hazard_stall) begin
        if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      end else begin
        fwd_cnt <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: directed scenarios plus randomized run against a history model.
module tb_fwd_scoreboard_unit;

  localparam int REG_AW  = 4;
  localparam int NUM_SRC = 2;
  localparam int D       = 2;
  localparam int SEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      freeze;
  logic                      ex_valid;
  logic [REG_AW-1:0]         ex_dest;
  logic                      ex_wb_en;
  logic                      ex_mem_r;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*REG_AW-1:0] src;
  logic [NUM_SRC*SEL_W-1:0]  sel;
  logic                      hazard_stall;
`ifdef FWD_STATS_EN
  logic [31:0]               fwd_cnt;
  logic [31:0]               stall_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  // History of the last D instructions that left EX: index 0 = most recent.
  int m_wr[D];
  int m_dest[D];
  int m_load[D];

  fwd_scoreboard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .ex_valid     (ex_valid),
    .ex_dest      (ex_dest),
    .ex_wb_en     (ex_wb_en),
    .ex_mem_r     (ex_mem_r),
    .src_valid    (src_valid),
    .src          (src),
    .sel          (sel),
    .hazard_stall (hazard_stall)
`ifdef FWD_STATS_EN
    ,
    .fwd_cnt      (fwd_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int sel_of(int i);
    return int'(sel[i*SEL_W +: SEL_W]);
  endfunction

  function automatic int src_of(int i);
    return int'(src[i*REG_AW +: REG_AW]);
  endfunction

  // Expected select: the most recent in-flight writer of the register, counted in stages.
  function automatic int exp_sel(int i);
    if (!src_valid[i] || src_of(i) == 15) return 0;
    for (int k = 0; k < D; k++)
      if (m_wr[k] != 0 && m_dest[k] == src_of(i)) return k + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    for (int i = 0; i < NUM_SRC; i++)
      if (exp_sel(i) == 1 && m_load[0] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      m_wr[k] = 0; m_dest[k] = 0; m_load[k] = 0;
    end
  endtask

  task automatic drive_ex(bit v, int d, bit wb, bit ld);
    ex_valid = v;
    ex_dest  = d[REG_AW-1:0];
    ex_wb_en = wb;
    ex_mem_r = ld;
  endtask

  task automatic drive_src(int i, bit v, int r);
    src_valid[i]            = v;
    src[i*REG_AW +: REG_AW] = r[REG_AW-1:0];
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!freeze && !rst) begin
      for (int k = D - 1; k > 0; k--) begin
        m_wr[k] = m_wr[k-1]; m_dest[k] = m_dest[k-1]; m_load[k] = m_load[k-1];
      end
      m_wr[0]   = (ex_valid && ex_wb_en) ? 1 : 0;
      m_dest[0] = int'(ex_dest);
      m_load[0] = ex_mem_r ? 1 : 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_ex(0, 0, 0, 0);
    src_valid = '0;
    src       = '0;
    freeze    = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    freeze = 1'b0;
    drive_ex(0, 0, 0, 0);
    src = '0;
    src_valid = '0;
    drive_src(0, 1, 3);
    drive_src(1, 1, 0);
    model_clear();
    #2;
    vectors++; if (sel_of(0) !== 0) begin errors++; $display("FAIL reset_sel0 got %0d want 0", sel_of(0)); end
    vectors++; if (sel_of(1) !== 0) begin errors++; $display("FAIL reset_sel1_r0 got %0d want 0", sel_of(1)); end
    vectors++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", hazard_stall); end
    @(negedge clk);
    rst = 1'b0;
    cycle();
    vectors++; if (sel_of(1) !== 0) begin errors++; $display("FAIL post_reset_r0 got %0d want 0", sel_of(1)); end
  endtask

  task automatic test_single_write();
    do_reset();
    drive_src(0, 1, 3);
    drive_ex(1, 3, 1, 0);
    cycle();
    drive_ex(0, 0, 0, 0);
    #1;
    vectors++; if (sel_of(0) !== 1) begin errors++; $display("FAIL single_stage1 got %0d want 1", sel_of(0)); end
    cycle();
    vectors++; if (sel_of(0) !== 2) begin errors++; $display("FAIL single_stage2 got %0d want 2", sel_of(0)); end
    cycle();
    vectors++; if (sel_of(0) !== 0) begin errors++; $display("FAIL single_retired got %0d want 0", sel_of(0)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_ex(1, 6, 1, 0);
    cycle();
    drive_ex(1, 5, 1, 0);
    cycle();
    drive_ex(0, 0, 0, 0);
    drive_src(0, 1, 5);
    drive_src(1, 1, 6);
    #1;
    vectors++; if (sel_of(0) !== 1) begin errors++; $display("FAIL b2b_r5 got %0d want 1", sel_of(0)); end
    vectors++; if (sel_of(1) !== 2) begin errors++; $display("FAIL b2b_r6 got %0d want 2", sel_of(1)); end
    drive_ex(1, 5, 1, 0);
    cycle();
    drive_ex(0, 0, 0, 0);
    #1;
    vectors++; if (sel_of(0) !== 1) begin errors++; $display("FAIL b2b_youngest got %0d want 1", sel_of(0)); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_ex(1, 2, 1, 1);
    cycle();
    drive_ex(0, 0, 0, 0);
    drive_src(0, 1, 2);
    #1;
    vectors++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b want 1", hazard_stall); end
    vectors++; if (sel_of(0) !== 1) begin errors++; $display("FAIL loaduse_sel got %0d want 1", sel_of(0)); end
    cycle();
    vectors++; if (sel_of(0) !== 2) begin errors++; $display("FAIL loaduse_after_sel got %0d want 2", sel_of(0)); end
    vectors++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL loaduse_after_stall got %b want 0", hazard_stall); end
  endtask

  task automatic test_no_fwd();
    do_reset();
    drive_ex(1, 15, 1, 0);
    cycle();
    drive_ex(1, 7, 1, 0);
    drive_src(0, 1, 15);
    drive_src(1, 1, 15);
    #1;
    vectors++; if (sel_of(0) !== 0) begin errors++; $display("FAIL pc_no_fwd got %0d want 0", sel_of(0)); end
    cycle();
    drive_ex(0, 0, 0, 0);
    drive_src(0, 0, 7);
    drive_src(1, 1, 7);
    #1;
    vectors++; if (sel_of(0) !== 0) begin errors++; $display("FAIL unused_src got %0d want 0", sel_of(0)); end
    vectors++; if (sel_of(1) !== 1) begin errors++; $display("FAIL used_src got %0d want 1", sel_of(1)); end
  endtask

  task automatic test_freeze();
    do_reset();
    drive_ex(1, 4, 1, 1);
    cycle();
    drive_ex(1, 9, 1, 0);
    drive_src(0, 1, 4);
    drive_src(1, 1, 9);
    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      vectors++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL freeze_stall c%0d got %b want 1", c, hazard_stall); end
      vectors++; if (sel_of(0) !== 1) begin errors++; $display("FAIL freeze_sel0 c%0d got %0d want 1", c, sel_of(0)); end
      vectors++; if (sel_of(1) !== 0) begin errors++; $display("FAIL freeze_hold c%0d got %0d want 0", c, sel_of(1)); end
    end
    freeze = 1'b0;
    drive_ex(0, 0, 0, 0);
    cycle();
    vectors++; if (sel_of(0) !== 2) begin errors++; $display("FAIL unfreeze_sel got %0d want 2", sel_of(0)); end
    vectors++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL unfreeze_stall got %b want 0", hazard_stall); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      freeze = ($urandom_range(0, 7) == 0);
      drive_ex($urandom_range(0, 3) != 0, ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      for (int i = 0; i < NUM_SRC; i++)
        drive_src(i, $urandom_range(0, 4) != 0, ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5));
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        vectors++;
        if (sel_of(i) !== exp_sel(i)) begin
          errors++; $display("FAIL rand_sel%0d n=%0d got %0d want %0d", i, n, sel_of(i), exp_sel(i));
        end
      end
      vectors++;
      if (hazard_stall !== exp_stall()) begin
        errors++; $display("FAIL rand_stall n=%0d got %b want %b", n, hazard_stall, exp_stall());
      end
      cycle();
    end
    freeze = 1'b0;
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    vectors++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL stats_fwd_reset got %0d want 0", fwd_cnt); end
    drive_ex(1, 3, 1, 0);
    cycle();
    drive_ex(0, 0, 0, 0);
    drive_src(0, 1, 3);
    cycle();
    cycle();
    drive_src(0, 0, 0);
    drive_ex(1, 4, 1, 1);
    cycle();
    drive_ex(0, 0, 0, 0);
    drive_src(0, 1, 4);
    cycle();
    drive_src(0, 0, 0);
    vectors++; if (fwd_cnt !== 32'd2) begin errors++; $display("FAIL stats_fwd got %0d want 2", fwd_cnt); end
    vectors++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL stats_stall got %0d want 1", stall_cnt); end
    drive_src(0, 1, 4);
    #1;
    rst = 1'b1;
    #1;
    vectors++; if (fwd_cnt !== 32'd0) begin errors++; $display("FAIL stats_fwd_midrst got %0d want 0", fwd_cnt); end
    vectors++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stats_stall_midrst got %0d want 0", stall_cnt); end
    vectors++; if (sel !== '0) begin errors++; $display("FAIL stats_sel_midrst got %h want 0", sel); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  task automatic test_mid_reset();
    do_reset();
    drive_ex(1, 8, 1, 0);
    drive_src(0, 1, 8);
    cycle();
    drive_ex(0, 0, 0, 0);
    #1;
    vectors++; if (sel_of(0) !== 1) begin errors++; $display("FAIL midrst_pre got %0d want 1", sel_of(0)); end
    rst = 1'b1;
    #1;
    vectors++; if (sel_of(0) !== 0) begin errors++; $display("FAIL midrst_async got %0d want 0", sel_of(0)); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_load_use();
    test_no_fwd();
    test_freeze();
    test_mid_reset();
    test_random();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
